// File: rtl/riscv_mem_arbiter.sv
// Shared memory port arbiter for fetch and load/store, with in-order response routing via an ID FIFO; RISCV_MEM_ARB_RR_EN selects round-robin ties.
// Latency: grant and rvalid routing are combinational (zero added cycles); selection is locked while the memory stalls a request.
// Backpressure: mem_gnt_i stalls the selected requester; a full ID FIFO (MAX_OUTSTANDING in flight) blocks new requests.
module riscv_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;

  logic          lock_q;
  src_e          lock_src_q;
  src_e          sel_src;
  logic          sel_req;
  logic          not_full;
  logic          fire;
  logic          pop;
  src_e          head_src;
  src_e          id_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef RISCV_MEM_ARB_RR_EN
  src_e last_q;

  always_comb begin
    sel_src = SRC_INSTR;
    if (lock_q)
      sel_src = lock_src_q;
    else if (data_req_i && instr_req_i)
      sel_src = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    else if (data_req_i)
      sel_src = SRC_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      last_q <= SRC_INSTR;
    else if (fire)
      last_q <= sel_src;
  end
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q;

  // Data has priority until fetch has waited STARVE_LIMIT cycles.
  always_comb begin
    sel_src = SRC_INSTR;
    if (lock_q)
      sel_src = lock_src_q;
    else if (data_req_i && (starve_q < STARVE_MAX))
      sel_src = SRC_DATA;
    else if (instr_req_i)
      sel_src = SRC_INSTR;
    else if (data_req_i)
      sel_src = SRC_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      starve_q <= '0;
    else if (!instr_req_i || instr_gnt_o)
      starve_q <= '0;
    else if (starve_q < STARVE_MAX)
      starve_q <= starve_q + 1'b1;
  end
`endif

  assign sel_req  = (sel_src == SRC_DATA) ? data_req_i : instr_req_i;
  assign not_full = (count_q != CNT_MAX);

  // Combinational outputs are gated by reset so nothing leaks while held in reset.
  assign mem_req_o   = rst_ni & sel_req & not_full;
  assign fire        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = fire & (sel_src == SRC_INSTR);
  assign data_gnt_o  = fire & (sel_src == SRC_DATA);

  assign mem_addr_o  = (sel_src == SRC_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (sel_src == SRC_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel_src == SRC_DATA) ? data_be_i    : 4'hF;
  assign mem_wdata_o = (sel_src == SRC_DATA) ? data_wdata_i : 32'h0;

  assign pop            = rst_ni & mem_rvalid_i & (count_q != '0);
  assign head_src       = id_q[rd_ptr_q];
  assign instr_rvalid_o = pop & (head_src == SRC_INSTR);
  assign data_rvalid_o  = pop & (head_src == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel_src;
    end else begin
      lock_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        id_q[i] <= SRC_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fire) begin
        id_q[wr_ptr_q] <= sel_src;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (fire && !pop)
        count_q <= count_q + 1'b1;
      else if (!fire && pop)
        count_q <= count_q - 1'b1;
      // A response with nothing outstanding has no owner: drop it and flag.
      if (mem_rvalid_i && (count_q == '0))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: expected responses queued at grant, checked at rvalid.
module tb_riscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb_q[$];    // {is_data, expected rdata}
  logic [31:0] pend_q[$];  // memory model: data to return, in order

  riscv_mem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rsp(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs and let combinational outputs settle.
  task automatic set_in(input logic ir, input logic dr, input logic g, input logic rv);
    instr_req_i  = ir;
    data_req_i   = dr;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    if (rv && pend_q.size() != 0) mem_rdata_i = pend_q.pop_front();
    else                          mem_rdata_i = 32'hDEAD_BEEF;
    #1;
  endtask

  // exp_g: 0 = no grant, 1 = fetch granted, 2 = data granted.
  task automatic end_cyc(input int exp_g);
    logic        exp_rsp;
    logic [32:0] e;
    chk("instr_gnt", 32'(instr_gnt_o), 32'(exp_g == 1));
    chk("data_gnt",  32'(data_gnt_o),  32'(exp_g == 2));
    exp_rsp = mem_rvalid_i && (sb_q.size() != 0);
    chk("rvalid_any", 32'(instr_rvalid_o | data_rvalid_o), 32'(exp_rsp));
    if (exp_rsp) begin
      e = sb_q.pop_front();
      chk("rvalid_dest", 32'({data_rvalid_o, instr_rvalid_o}), e[32] ? 32'd2 : 32'd1);
      chk("rdata", e[32] ? data_rdata_o : instr_rdata_o, e[31:0]);
    end
    if (exp_g != 0)
      sb_q.push_back({exp_g == 2, rsp(exp_g == 2 ? data_addr_i : instr_addr_i)});
    if (mem_req_o && mem_gnt_i)
      pend_q.push_back(rsp(mem_addr_o));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eg;
    rst_ni       = 1'b0;
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;
    instr_addr_i = 32'h0;
    data_addr_i  = 32'h100;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_wdata_i = 32'h0;

    // Reset with everything asserted: nothing may escape.
    #2;
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_gnts", 32'({instr_gnt_o, data_gnt_o}), 0);
    chk("rst_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(err_o), 0);
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fetch only, response two cycles after grant.
    instr_addr_i = 32'h0;
    set_in(1, 0, 1, 0); end_cyc(1);
    chk("t1_busy_on", 32'(busy_o), 1);
    set_in(0, 0, 1, 0); end_cyc(0);
    set_in(0, 0, 1, 1);
    chk("t1_instr_rdata", instr_rdata_o, 32'h0000_0013);
    chk("t1_data_rvalid", 32'(data_rvalid_o), 0);
    end_cyc(0);
    chk("t1_busy_off", 32'(busy_o), 0);

    // Both requesting continuously; memory answers one cycle after each grant.
    for (int i = 0; i < 10; i++) begin
      instr_addr_i = 32'h1000 + 32'(4 * i);
      data_addr_i  = 32'h2000 + 32'(4 * i);
`ifdef RISCV_MEM_ARB_RR_EN
      eg = (i % 2 == 0) ? 2 : 1;
`else
      eg = (i % 5 == 4) ? 1 : 2;
`endif
      set_in(1, 1, 1, i != 0);
      end_cyc(eg);
    end
    set_in(0, 0, 1, 1); end_cyc(0);
    chk("t2_drain", sb_q.size(), 0);

    // Data store stalled 3 cycles, fetch arrives meanwhile.
    data_addr_i = 32'h3000; instr_addr_i = 32'h4000;
    data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hCAFE_0000;
    set_in(0, 1, 0, 0);
    chk("t3_req", 32'(mem_req_o), 1);
    chk("t3_addr0", mem_addr_o, 32'h3000);
    chk("t3_we", 32'(mem_we_o), 1);
    chk("t3_be", 32'(mem_be_o), 32'h3);
    chk("t3_wdata", mem_wdata_o, 32'hCAFE_0000);
    end_cyc(0);
    set_in(1, 1, 0, 0); chk("t3_addr1", mem_addr_o, 32'h3000); end_cyc(0);
    set_in(1, 1, 0, 0); chk("t3_addr2", mem_addr_o, 32'h3000); end_cyc(0);
    set_in(1, 1, 1, 0); end_cyc(2);
    set_in(1, 0, 1, 1); end_cyc(1);
    set_in(0, 0, 1, 1); end_cyc(0);
    data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
    chk("t3_drain", sb_q.size(), 0);

    // Fetch stalled, data arrives: lock must keep fetch selected.
    instr_addr_i = 32'h5000; data_addr_i = 32'h5800;
    set_in(1, 0, 0, 0);
    chk("t3b_addr", mem_addr_o, 32'h5000);
    chk("t3b_attr", 32'({mem_we_o, mem_be_o}), 32'h0F);
    chk("t3b_wdata", mem_wdata_o, 32'h0);
    end_cyc(0);
    set_in(1, 1, 0, 0); chk("t3b_lock_addr", mem_addr_o, 32'h5000); end_cyc(0);
    set_in(1, 1, 1, 0); end_cyc(1);
    set_in(0, 1, 1, 1); end_cyc(2);
    set_in(0, 0, 0, 1); end_cyc(0);
    chk("t3b_drain", sb_q.size(), 0);

    // FIFO full: third request waits until the cycle after the first pop.
    instr_addr_i = 32'h6000; data_addr_i = 32'h7000;
    set_in(1, 0, 1, 0); end_cyc(1);
    set_in(0, 1, 1, 0); end_cyc(2);
    instr_addr_i = 32'h6004;
    set_in(1, 0, 1, 0); chk("t4_full_blk", 32'(mem_req_o), 0); end_cyc(0);
    set_in(1, 0, 1, 1); chk("t4_full_pop", 32'(mem_req_o), 0); end_cyc(0);
    set_in(1, 0, 1, 1); chk("t4_reissue", 32'(mem_req_o), 1); end_cyc(1);
    chk("t4_busy", 32'(busy_o), 1);
    set_in(0, 0, 0, 1); end_cyc(0);
    chk("t4_idle", 32'(busy_o), 0);
    chk("t4_drain", sb_q.size(), 0);

    // Stray response with nothing outstanding.
    chk("t5_err_pre", 32'(err_o), 0);
    set_in(0, 0, 0, 1); end_cyc(0);
    chk("t5_err_set", 32'(err_o), 1);
    set_in(0, 0, 0, 0); end_cyc(0);
    set_in(0, 0, 0, 0); end_cyc(0);
    chk("t5_err_sticky", 32'(err_o), 1);

    // Reset with one fetch outstanding; its late response must be dropped.
    instr_addr_i = 32'h8000;
    set_in(1, 0, 1, 0); end_cyc(1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_err", 32'(err_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_req", 32'(mem_req_o), 0);
    instr_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    sb_q.delete();
    set_in(0, 0, 0, 1);
    chk("t6_no_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 0);
    end_cyc(0);
    chk("t6_err", 32'(err_o), 1);
    set_in(0, 0, 0, 0); end_cyc(0);
    chk("t6_err_sticky", 32'(err_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
